hazard_control: RTL

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard control: load-use stall, branch flush, memory-wait stall with watchdog.
// Outputs are combinational from state and inputs in the same cycle; the memory wait freezes all four stages.
module hazard_control #(
  parameter int unsigned MEM_TO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] R2_1,
  input  logic [3:0] R3_1,
  input  logic [1:0] ExtndSel0,
  input  logic       VF0,
  input  logic [3:0] DestR_2,
  input  logic       VF2,
  input  logic       MemRd2,
  input  logic       MemReq3,
  input  logic       MemDone,
  input  logic       BranchTaken,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MemErr,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MWAIT = 2'b01,
    ERR   = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [7:0] MEM_TO_C = 8'(MEM_TO);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  logic r2_used, r3_used, load_use, mem_hold;
  logic stall_all, stall_fd, flush_d, flush_e, run_eval;

  assign r2_used  = ~ExtndSel0[1];
  assign r3_used  = (ExtndSel0 == 2'b00);
  assign load_use = MemRd2 & (DestR_2 != 4'd0) & (VF0 == VF2) &
                    ((r2_used & (R2_1 == DestR_2)) | (r3_used & (R3_1 == DestR_2)));
  assign mem_hold = MemReq3 & ~MemDone;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    stall_all = 1'b0;
    stall_fd  = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    run_eval  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_hold) begin
          stall_all = 1'b1;
          state_d   = MWAIT;
          cnt_d     = 8'd1;
        end else begin
          run_eval = 1'b1;
        end
      end
      MWAIT: begin
        if (MemDone) begin
          // Acknowledge releases the pipe this cycle, so decode hazards apply again.
          state_d  = RUN;
          cnt_d    = 8'd0;
          run_eval = 1'b1;
        end else begin
          stall_all = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_q == MEM_TO_C) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        stall_all = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase

    if (run_eval) begin
      if (BranchTaken) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_fd = 1'b1;
        flush_e  = 1'b1;
      end
    end
  end

  // Pipeline controls are forced low for the whole time reset is held.
  assign StallF = rst & (stall_all | stall_fd);
  assign StallD = rst & (stall_all | stall_fd);
  assign StallE = rst & stall_all;
  assign StallM = rst & stall_all;
  assign FlushD = rst & flush_d;
  assign FlushE = rst & flush_e;
  assign MemErr = mem_err_q;
  assign State  = state_q;

endmodule
